counter_window: RTL and testbench

Parametrised successor to the single-mode clap counter. Measures one timing window: counts enabled clock ticks from 0 to MAXCOUNT, then either stops or reloads, depending on AUTO_RELOAD. While the window is open it timestamps each hit (clap) pulse and counts hits. Sits between the input/debounce logic and the game scoring/display logic.

---
 rtl/counter_window.sv | 136 +++++++++++++
 tb/tb_counter_window.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_window.sv
`default_nettype none
// ============================================================================
// Module      : counter_window
// Description : Timing-window counter. Counts enabled ticks up to MAXCOUNT,
//               timestamps hits inside the window, and counts them.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_window #(
    parameter int WIDTH       = 17,
    parameter int MAXCOUNT    = 66080,
    parameter int AUTO_RELOAD = 0,
    parameter int HIT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             en,
    input  logic             hit,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done,
    output logic [WIDTH-1:0] hit_time,
    output logic             hit_valid,
    output logic [HIT_W-1:0] hit_cnt
);

    localparam logic [1:0]       c_S_IDLE    = 2'd0;
    localparam logic [1:0]       c_S_COUNT   = 2'd1;
    localparam logic [1:0]       c_S_DONE    = 2'd2;
    localparam logic [WIDTH-1:0] c_MAX_COUNT = WIDTH'(MAXCOUNT);
    localparam logic             c_RELOAD    = (AUTO_RELOAD != 0);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_running;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic             r_done;
    logic             w_done_next;
    logic [WIDTH-1:0] r_hit_time;
    logic [WIDTH-1:0] w_hit_time_next;
    logic             r_hit_valid;
    logic             w_hit_valid_next;
    logic [HIT_W-1:0] r_hit_cnt;
    logic [HIT_W-1:0] w_hit_cnt_next;
    logic             w_term;
    logic             w_counting;

    assign w_term     = (r_count == c_MAX_COUNT);
    assign w_counting = (r_state == c_S_COUNT) && !go;

    // State register; running is registered alongside so it tracks state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_S_IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_running <= (w_state_next == c_S_COUNT);
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (go) begin
            w_state_next = c_S_COUNT;
        end else begin
            case (r_state)
                c_S_COUNT: begin
                    if (en && w_term && !c_RELOAD) begin
                        w_state_next = c_S_DONE;
                    end
                end
                c_S_IDLE:  w_state_next = c_S_IDLE;
                c_S_DONE:  w_state_next = c_S_DONE;
                default:   w_state_next = c_S_IDLE;
            endcase
        end
    end

    // Datapath next values: go wins over everything, otherwise only COUNT acts.
    always_comb begin
        w_count_next     = r_count;
        w_done_next      = 1'b0;
        w_hit_valid_next = 1'b0;
        w_hit_time_next  = r_hit_time;
        w_hit_cnt_next   = r_hit_cnt;
        if (go) begin
            w_count_next   = '0;
            w_hit_cnt_next = '0;
        end else if (w_counting) begin
            if (en) begin
                if (w_term) begin
                    w_done_next = 1'b1;
                    if (c_RELOAD) begin
                        w_count_next = '0;
                    end
                end else begin
                    w_count_next = r_count + WIDTH'(1);
                end
            end
            if (hit) begin
                w_hit_time_next  = r_count;
                w_hit_valid_next = 1'b1;
                if (!(&r_hit_cnt)) begin
                    w_hit_cnt_next = r_hit_cnt + HIT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_done      <= 1'b0;
            r_hit_time  <= '0;
            r_hit_valid <= 1'b0;
            r_hit_cnt   <= '0;
        end else begin
            r_count     <= w_count_next;
            r_done      <= w_done_next;
            r_hit_time  <= w_hit_time_next;
            r_hit_valid <= w_hit_valid_next;
            r_hit_cnt   <= w_hit_cnt_next;
        end
    end

    assign count     = r_count;
    assign running   = r_running;
    assign done      = r_done;
    assign hit_time  = r_hit_time;
    assign hit_valid = r_hit_valid;
    assign hit_cnt   = r_hit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_counter_window.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_window
// Description : Self-checking bench: stop-mode and reload-mode instances driven
//               by shared stimulus, checked against vector table and a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_window;

    localparam int c_W     = 8;
    localparam int c_MAX   = 5;
    localparam int c_HW    = 2;
    localparam int c_HSAT  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic go = 1'b0;
    logic en = 1'b0;
    logic hit = 1'b0;

    logic [c_W-1:0]  count0, count1, ht0, ht1;
    logic            run0, run1, done0, done1, hv0, hv1;
    logic [c_HW-1:0] hc0, hc1;

    int passed = 0;
    int total  = 0;

    // Reference model, one slot per instance (index = AUTO_RELOAD)
    int m_mode[2];   // 0 idle, 1 counting, 2 finished
    int m_count[2];
    int m_ht[2];
    int m_hc[2];
    int m_done[2];
    int m_hv[2];

    always #5 clk = ~clk;

    counter_window #(.WIDTH(c_W), .MAXCOUNT(c_MAX), .AUTO_RELOAD(0), .HIT_W(c_HW)) dut0 (
        .clk(clk), .reset(reset), .go(go), .en(en), .hit(hit),
        .count(count0), .running(run0), .done(done0),
        .hit_time(ht0), .hit_valid(hv0), .hit_cnt(hc0)
    );

    counter_window #(.WIDTH(c_W), .MAXCOUNT(c_MAX), .AUTO_RELOAD(1), .HIT_W(c_HW)) dut1 (
        .clk(clk), .reset(reset), .go(go), .en(en), .hit(hit),
        .count(count1), .running(run1), .done(done1),
        .hit_time(ht1), .hit_valid(hv1), .hit_cnt(hc1)
    );

    typedef struct {
        logic go, en, hit;
        int   count;
        int   run;
        int   done;
        int   ht;
        int   hv;
        int   hc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_count[i] = 0; m_ht[i] = 0;
            m_hc[i] = 0;   m_done[i] = 0;  m_hv[i] = 0;
        end
    endtask

    task automatic mstep(input int i, input logic g, input logic e, input logic h);
        m_done[i] = 0;
        m_hv[i]   = 0;
        if (g) begin
            m_mode[i] = 1; m_count[i] = 0; m_hc[i] = 0;
        end else if (m_mode[i] == 1) begin
            if (h) begin
                m_ht[i] = m_count[i];
                m_hv[i] = 1;
                m_hc[i] = (m_hc[i] < c_HSAT) ? m_hc[i] + 1 : c_HSAT;
            end
            if (e) begin
                if (m_count[i] == c_MAX) begin
                    m_done[i] = 1;
                    if (i == 1) m_count[i] = 0;
                    else        m_mode[i] = 2;
                end else begin
                    m_count[i] = m_count[i] + 1;
                end
            end
        end
    endtask

    task automatic cmp_models(input string tag);
        chk({tag, " d0 count"},  int'(count0), m_count[0]);
        chk({tag, " d0 run"},    int'(run0),   int'(m_mode[0] == 1));
        chk({tag, " d0 done"},   int'(done0),  m_done[0]);
        chk({tag, " d0 htime"},  int'(ht0),    m_ht[0]);
        chk({tag, " d0 hvalid"}, int'(hv0),    m_hv[0]);
        chk({tag, " d0 hcnt"},   int'(hc0),    m_hc[0]);
        chk({tag, " d1 count"},  int'(count1), m_count[1]);
        chk({tag, " d1 run"},    int'(run1),   int'(m_mode[1] == 1));
        chk({tag, " d1 done"},   int'(done1),  m_done[1]);
        chk({tag, " d1 htime"},  int'(ht1),    m_ht[1]);
        chk({tag, " d1 hvalid"}, int'(hv1),    m_hv[1]);
        chk({tag, " d1 hcnt"},   int'(hc1),    m_hc[1]);
    endtask

    // Inputs are changed 1 time unit after a rising edge and sampled at the next.
    task automatic cycle(input logic g, input logic e, input logic h, input string tag);
        go = g; en = e; hit = h;
        @(posedge clk);
        #1;
        mstep(0, g, e, h);
        mstep(1, g, e, h);
        cmp_models(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        mreset();
        cmp_models(tag);
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic g, e, h, input int c, r, d, t, v, n);
        vec_t x;
        x.go = g; x.en = e; x.hit = h;
        x.count = c; x.run = r; x.done = d; x.ht = t; x.hv = v; x.hc = n;
        return x;
    endfunction

    initial begin
        int first_done;
        int second_done;
        int ndone;

        // go en hit | count run done htime hvalid hcnt (stop-mode instance)
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 3, 1, 0, 2, 1, 1));
        vecs.push_back(mk(0, 1, 0, 4, 1, 0, 2, 0, 1));
        vecs.push_back(mk(0, 1, 1, 5, 1, 0, 4, 1, 2));
        vecs.push_back(mk(0, 1, 0, 5, 0, 1, 4, 0, 2));
        vecs.push_back(mk(0, 1, 1, 5, 0, 0, 4, 0, 2));
        vecs.push_back(mk(0, 0, 0, 5, 0, 0, 4, 0, 2));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2, 1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2, 1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 1, 0, 3, 1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4, 1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 1, 0, 5, 1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 0, 0, 5, 1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 1, 0, 5, 0, 1, 4, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 3));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0));

        mreset();
        repeat (2) @(posedge clk);
        #1;
        cmp_models("reset");
        reset = 1'b0;

        for (int i = 0; i < 10; i++) cycle(0, 1, 0, "idle");

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].go, vecs[i].en, vecs[i].hit, "vecmodel");
            chk($sformatf("vec%0d count", i),  int'(count0), vecs[i].count);
            chk($sformatf("vec%0d run", i),    int'(run0),   vecs[i].run);
            chk($sformatf("vec%0d done", i),   int'(done0),  vecs[i].done);
            chk($sformatf("vec%0d htime", i),  int'(ht0),    vecs[i].ht);
            chk($sformatf("vec%0d hvalid", i), int'(hv0),    vecs[i].hv);
            chk($sformatf("vec%0d hcnt", i),   int'(hc0),    vecs[i].hc);
        end

        // Reload mode: done must pulse twice, six enabled edges apart.
        cycle(1, 0, 0, "reload go");
        ndone = 0; first_done = -1; second_done = -1;
        for (int k = 1; k <= 14; k++) begin
            cycle(0, 1, 0, "reload");
            if (done1) begin
                ndone++;
                if (first_done < 0) first_done = k;
                else second_done = k;
            end
        end
        chk("reload done pulses", ndone, 2);
        chk("reload first done", first_done, 6);
        chk("reload done spacing", second_done - first_done, 6);
        chk("reload final count", int'(count1), 2);

        // Reset asserted mid-window, between clock edges.
        cycle(1, 0, 0, "midreset go");
        repeat (3) cycle(0, 1, 0, "midreset run");
        chk("midreset pre count", int'(count0), 3);
        async_reset("midreset");
        chk("midreset count", int'(count0), 0);
        chk("midreset running", int'(run0), 0);
        repeat (3) cycle(0, 1, 1, "post reset idle");

        for (int n = 0; n < 1500; n++) begin
            cycle(($urandom_range(15) == 0), ($urandom_range(3) != 0),
                  ($urandom_range(3) == 0), "rand");
            if ($urandom_range(199) == 0) async_reset("rand reset");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
